// File: rtl/disp_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Used by disp_scan_timer, disp_scan_ctrl and the disp_scan_ctrl_if bus.
package disp_pkg;

    localparam int SEG_W      = 8;
    localparam int ADDR_W     = 3;
    localparam int MAX_DIGITS = 1 << ADDR_W;

    // Scan FSM: segments lit during SCAN, forced dark during BLANK.
    typedef enum logic {
        SCAN  = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

    // One segment pattern per addressable digit (the full address space).
    typedef logic [SEG_W-1:0] digit_arr_t [MAX_DIGITS];

    // True when a digit index addresses a digit that actually exists.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] addr,
                                        input int                digits);
        return int'(addr) < digits;
    endfunction

endpackage : disp_pkg

// File: rtl/disp_scan_ctrl_if.sv
// Bus bundle between the scan controller, the common digit driver and the host.
// The bright input exists only when DISP_BRIGHT_EN is defined.
interface disp_scan_ctrl_if;
    import disp_pkg::*;

    // Scan pacing / common driver side
    logic              scan_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              v_sync;
    logic              com_cnt_en;
    logic              update_en;
    logic [SEG_W-1:0]  seg_data;
    logic              seg_blank;

    // Host frame-buffer side
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [SEG_W-1:0]  host_wdata;
    logic              host_commit;
    logic              host_ready;
    logic              commit_ack;

`ifdef DISP_BRIGHT_EN
    logic [2:0]        bright;
`endif

    // Controller view
    modport slave (
`ifdef DISP_BRIGHT_EN
        input  bright,
`endif
        input  scan_en, mem_addr, v_sync,
        input  host_we, host_addr, host_wdata, host_commit,
        output com_cnt_en, update_en, seg_data, seg_blank,
        output host_ready, commit_ack
    );

    // Host / driver view
    modport master (
`ifdef DISP_BRIGHT_EN
        output bright,
`endif
        output scan_en, mem_addr, v_sync,
        output host_we, host_addr, host_wdata, host_commit,
        input  com_cnt_en, update_en, seg_data, seg_blank,
        input  host_ready, commit_ack
    );

endinterface : disp_scan_ctrl_if

// File: rtl/disp_scan_timer.sv
// Dwell/blank timing for the digit scan. Each digit is lit for 2**DWELL_W
// enabled cycles, then dark for BLANK_CYC cycles; the step pulse fires on the
// last dark cycle so the address change is hidden inside the gap.
module disp_scan_timer
    import disp_pkg::*;
#(
    parameter int DWELL_W   = 10,
    parameter int BLANK_CYC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_scan_en,
    output logic               o_com_cnt_en,
    output logic               o_seg_blank,
    output logic [DWELL_W-1:0] o_dwell_cnt
);

    localparam int                 BLANK_W    = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYC - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = '1;

    scan_state_t        r_state;
    scan_state_t        w_state_next;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [DWELL_W-1:0] w_dwell_next;
    logic [BLANK_W-1:0] r_blank_cnt;
    logic [BLANK_W-1:0] w_blank_next;

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SCAN;
            r_dwell_cnt <= '0;
            r_blank_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_dwell_cnt <= w_dwell_next;
            r_blank_cnt <= w_blank_next;
        end
    end

    // Next state, counter advance, step pulse and base blanking
    always_comb begin
        w_state_next = r_state;
        w_dwell_next = r_dwell_cnt;
        w_blank_next = r_blank_cnt;
        o_com_cnt_en = 1'b0;
        o_seg_blank  = 1'b1;   // dark while frozen or in the gap
        if (i_scan_en) begin
            case (r_state)
                SCAN: begin
                    o_seg_blank = 1'b0;
                    if (r_dwell_cnt == DWELL_LAST) begin
                        w_dwell_next = '0;
                        w_state_next = BLANK;
                    end else begin
                        w_dwell_next = r_dwell_cnt + DWELL_W'(1);
                    end
                end
                BLANK: begin
                    if (r_blank_cnt == BLANK_LAST) begin
                        o_com_cnt_en = 1'b1;
                        w_blank_next = '0;
                        w_state_next = SCAN;
                    end else begin
                        w_blank_next = r_blank_cnt + BLANK_W'(1);
                    end
                end
                default: w_state_next = SCAN;
            endcase
        end
    end

    assign o_dwell_cnt = r_dwell_cnt;

endmodule : disp_scan_timer

// File: rtl/disp_scan_ctrl.sv
// Scan scheduler and double-buffered frame store for the 7-segment display.
// The host fills the shadow buffer and commits; the shadow is copied into the
// visible buffer on the step off the last digit, so a frame never tears.
// Optional feature macro: DISP_BRIGHT_EN (adds PWM brightness via bus.bright).
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DIGITS    = 6,
    parameter int DWELL_W   = 10,
    parameter int BLANK_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    disp_scan_ctrl_if.slave  bus
);

    logic               w_com_cnt_en;
    logic               w_base_blank;
    logic               w_seg_blank;
    logic [DWELL_W-1:0] w_dwell_cnt;
    logic               w_addr_ok;
    logic               w_wr_fire;
    logic               w_commit_fire;
    logic               w_swap;
    logic [MAX_DIGITS-1:0] w_wr_sel;

    logic               r_pending;
    digit_arr_t         r_shadow;
    digit_arr_t         r_active;

    disp_scan_timer #(
        .DWELL_W   (DWELL_W),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_scan_en    (bus.scan_en),
        .o_com_cnt_en (w_com_cnt_en),
        .o_seg_blank  (w_base_blank),
        .o_dwell_cnt  (w_dwell_cnt)
    );

`ifdef DISP_BRIGHT_EN
    // PWM: the top three dwell bits sweep 0..7 across the on-time, so the
    // digit stays lit for (bright+1)/8 of it. Outside SCAN the dwell count is
    // zero and the base blank already dominates.
    assign w_seg_blank = w_base_blank | (w_dwell_cnt[DWELL_W-1 -: 3] > bus.bright);
`else
    logic w_unused_dwell;
    assign w_unused_dwell = ^w_dwell_cnt;
    assign w_seg_blank    = w_base_blank;
`endif

    // Host writes and commits are only accepted while no commit is in flight.
    assign w_wr_fire     = bus.host_we & ~r_pending;
    assign w_commit_fire = bus.host_commit & ~r_pending;
    // Swap on the step off the last digit (v_sync low), only while scanning.
    assign w_swap        = r_pending & w_com_cnt_en & ~bus.v_sync;

    // Per-digit write select; digits past DIGITS never get selected.
    generate
        for (genvar gi = 0; gi < MAX_DIGITS; gi++) begin : g_wr_sel
            assign w_wr_sel[gi] = w_wr_fire
                                  && (bus.host_addr == ADDR_W'(gi))
                                  && (gi < DIGITS);
        end
    endgenerate

    // Shadow buffer: host-side writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_DIGITS; i++) r_shadow[i] <= '0;
        end else begin
            for (int i = 0; i < MAX_DIGITS; i++) begin
                if (w_wr_sel[i]) r_shadow[i] <= bus.host_wdata;
            end
        end
    end

    // Active buffer: whole-frame copy at the frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_DIGITS; i++) r_active[i] <= '0;
        end else if (w_swap) begin
            r_active <= r_shadow;
        end
    end

    // Commit-pending flag: set by an accepted commit, cleared by the swap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if (w_swap) begin
            r_pending <= 1'b0;
        end else if (w_commit_fire) begin
            r_pending <= 1'b1;
        end
    end

    assign w_addr_ok = addr_valid(bus.mem_addr, DIGITS);

    assign bus.com_cnt_en = w_com_cnt_en;
    assign bus.update_en  = bus.scan_en;
    assign bus.seg_blank  = w_seg_blank;
    assign bus.seg_data   = (w_seg_blank || !w_addr_ok) ? '0 : r_active[bus.mem_addr];
    assign bus.host_ready = ~r_pending;
    assign bus.commit_ack = w_swap;

endmodule : disp_scan_ctrl
